uart_rx: RTL and testbench

- UART receiver sitting directly behind the SOC's RXD pin; it is the stage that consumes the serial stream the bench drives on RXD.
- Deserialises 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit, no parity) into bytes.
- Hands each byte to the SOC's memory-mapped I/O via a valid/ready handshake.
- Flags framing errors and overruns.

---
 rtl/uart_rx.sv | 244 ++++++++++++++++++++++++
 tb/tb_uart_rx.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver.
//   RXD -> two-flop synchroniser -> start/data/stop FSM (samples at bit
//   centres) -> valid/ready output stage.
// Build option: define UART_RX_FIFO_EN to replace the single holding register
// with a 4-entry FIFO; leave it undefined for the single-entry register.
//
// Handshake: a byte transfers on a rising CLK edge where rx_valid and rx_ready
// are both 1. While rx_valid is 1, rx_data is held stable until that transfer.
// rx_ready has no effect while rx_valid is 0.
module uart_rx #(
   parameter int CLK_FREQ_HZ = 12000000,
   parameter int BAUD_RATE   = 115200
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       RXD,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_err,
   output logic       overrun,
   input  logic       overrun_clr,
   output logic [2:0] dbg_state
);

   localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
   localparam int CNT_W        = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

   // Fewer than 4 clocks per bit leaves no room for centre sampling.
   if (CLKS_PER_BIT < 4) begin : g_cpb_check
      $error("uart_rx: CLKS_PER_BIT must be >= 4");
   end

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_START     = 3'd1,
      S_DATA      = 3'd2,
      S_STOP      = 3'd3,
      S_WAIT_IDLE = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic [1:0]        sync_q;
   logic              rxd_s;
   logic [CNT_W-1:0]  clk_cnt_q, clk_cnt_d;
   logic [2:0]        bit_cnt_q, bit_cnt_d;
   logic [7:0]        shift_q, shift_d;
   logic              push_byte;
   logic              stop_bad;
   logic              frame_err_q;
   logic              overrun_q;
   logic              ovr_set;
   logic              pop;

   assign rxd_s     = sync_q[1];
   assign dbg_state = state_q;
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;

   // Two-flop synchroniser; idles high so reset does not look like a start bit.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], RXD};
      end
   end

   // FSM state register plus its counters and shift register.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q   <= S_IDLE;
         clk_cnt_q <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
      end else begin
         state_q   <= state_d;
         clk_cnt_q <= clk_cnt_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
      end
   end

   // Next-state logic: half-bit wait to centre on the start bit, then full-bit steps.
   always_comb begin
      state_d   = state_q;
      clk_cnt_d = clk_cnt_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      case (state_q)
         S_IDLE: begin
            clk_cnt_d = '0;
            if (!rxd_s) begin
               state_d = S_START;
            end
         end
         S_START: begin
            if (clk_cnt_q == HALF_LAST) begin
               clk_cnt_d = '0;
               bit_cnt_d = '0;
               // Line back high at mid start bit: treat as a glitch.
               state_d   = rxd_s ? S_IDLE : S_DATA;
            end else begin
               clk_cnt_d = clk_cnt_q + CNT_W'(1);
            end
         end
         S_DATA: begin
            if (clk_cnt_q == BIT_LAST) begin
               clk_cnt_d = '0;
               shift_d   = {rxd_s, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  state_d = S_STOP;
               end
            end else begin
               clk_cnt_d = clk_cnt_q + CNT_W'(1);
            end
         end
         S_STOP: begin
            if (clk_cnt_q == BIT_LAST) begin
               clk_cnt_d = '0;
               state_d   = rxd_s ? S_IDLE : S_WAIT_IDLE;
            end else begin
               clk_cnt_d = clk_cnt_q + CNT_W'(1);
            end
         end
         S_WAIT_IDLE: begin
            // A held-low line (break) reports once, then waits for idle.
            clk_cnt_d = '0;
            if (rxd_s) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d   = S_IDLE;
            clk_cnt_d = '0;
            bit_cnt_d = '0;
         end
      endcase
   end

   // FSM outputs: completed byte or bad stop bit, both in the stop-sample cycle.
   always_comb begin
      push_byte = 1'b0;
      stop_bad  = 1'b0;
      if (state_q == S_STOP && clk_cnt_q == BIT_LAST) begin
         push_byte = rxd_s;
         stop_bad  = ~rxd_s;
      end
   end

   // Frame error pulse and sticky overrun flag (a new overrun beats the clear).
   always_ff @(posedge CLK) begin
      if (RESET) begin
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         frame_err_q <= stop_bad;
         overrun_q   <= ovr_set | (overrun_q & ~overrun_clr);
      end
   end

`ifdef UART_RX_FIFO_EN

   logic [7:0] mem_q [4];
   logic [1:0] wr_ptr_q, wr_ptr_d;
   logic [1:0] rd_ptr_q, rd_ptr_d;
   logic [2:0] count_q, count_d;
   logic       do_write;

   assign rx_valid = (count_q != 3'd0);
   assign rx_data  = mem_q[rd_ptr_q];
   assign pop      = rx_valid & rx_ready;

   // FIFO control: a pop in the same cycle frees the slot a full push needs.
   always_comb begin
      do_write = push_byte & ((count_q != 3'd4) | pop);
      ovr_set  = push_byte & (count_q == 3'd4) & ~pop;
      wr_ptr_d = do_write ? wr_ptr_q + 2'd1 : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + 2'd1 : rd_ptr_q;
      count_d  = count_q + {2'b00, do_write} - {2'b00, pop};
   end

   // FIFO storage and pointers.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < 4; i++) begin
            mem_q[i] <= 8'h00;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (do_write) begin
            mem_q[wr_ptr_q] <= shift_q;
         end
      end
   end

`else

   logic [7:0] data_q, data_d;
   logic       valid_q, valid_d;

   assign rx_valid = valid_q;
   assign rx_data  = data_q;
   assign pop      = valid_q & rx_ready;

   // Single holding register: load when empty or being emptied, else drop.
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      ovr_set = 1'b0;
      if (push_byte) begin
         if (!valid_q || pop) begin
            data_d  = shift_q;
            valid_d = 1'b1;
         end else begin
            ovr_set = 1'b1;
         end
      end else if (pop) begin
         valid_d = 1'b0;
      end
   end

   // Holding register state.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         data_q  <= 8'h00;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed + randomized bench for uart_rx at 10 clocks per bit.
// The reference model tracks bytes held by the receiver as a queue of fixed
// capacity (1, or 4 with UART_RX_FIFO_EN) and the list of bytes the consumer
// should see, in order.
`timescale 1ns/1ps
module tb_uart_rx;

   localparam int CLK_FREQ_HZ = 1000000;
   localparam int BAUD_RATE   = 100000;
`ifdef UART_RX_FIFO_EN
   localparam int CAP = 4;
`else
   localparam int CAP = 1;
`endif

   logic       CLK = 1'b0;
   logic       RESET;
   logic       RXD;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       frame_err;
   logic       overrun;
   logic       overrun_clr;
   logic [2:0] dbg_state;

   int checks = 0;
   int errors = 0;
   int unsigned cyc = 0;

   uart_rx #(
      .CLK_FREQ_HZ(CLK_FREQ_HZ),
      .BAUD_RATE  (BAUD_RATE)
   ) dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .RXD        (RXD),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .frame_err  (frame_err),
      .overrun    (overrun),
      .overrun_clr(overrun_clr),
      .dbg_state  (dbg_state)
   );

   // Clock and cycle counter.
   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   // Monitor: records transfers, valid-high cycles, valid rises and frame_err cycles.
   logic [7:0]  got_q[$];
   int          valid_cycles = 0;
   int          ferr_cnt = 0;
   int unsigned rise_cyc = 0;
   logic        prev_valid = 1'b0;
   always @(negedge CLK) begin
      if (RESET === 1'b0) begin
         if (rx_valid && rx_ready) got_q.push_back(rx_data);
         if (rx_valid) valid_cycles++;
         if (rx_valid && !prev_valid) rise_cyc = cyc;
         if (frame_err) ferr_cnt++;
      end
      prev_valid = rx_valid;
   end

   // Reference model.
   logic [7:0]  held_q[$];
   logic [7:0]  exp_q[$];
   logic        ovr_exp = 1'b0;
   int          ferr_exp = 0;
   int          got_rd = 0;
   int unsigned frame_cyc = 0;

   task automatic model_frame(input logic [7:0] b, input logic ready_now);
      if (ready_now && held_q.size() > 0) exp_q.push_back(held_q.pop_front());
      if (held_q.size() < CAP) held_q.push_back(b);
      else ovr_exp = 1'b1;
   endtask

   task automatic model_pop_one();
      if (held_q.size() > 0) exp_q.push_back(held_q.pop_front());
   endtask

   task automatic model_pop_all();
      while (held_q.size() > 0) exp_q.push_back(held_q.pop_front());
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic compare_delivered(input string tag);
      check({tag, "_count"}, 32'(got_q.size() - got_rd), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && got_rd + i < got_q.size(); i++)
         check({tag, "_byte"}, 32'(got_q[got_rd + i]), 32'(exp_q[i]));
      got_rd = got_q.size();
      exp_q.delete();
      check({tag, "_ferr"}, 32'(ferr_cnt), 32'(ferr_exp));
   endtask

   // Driver tasks.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle(input int n);
      RXD = 1'b1;
      repeat (n) tick();
   endtask

   // Drives n_cyc cycles of an 8N1 frame (100 = full frame); optionally pulses
   // rx_ready for one cycle starting ready_at cycles after the falling edge.
   task automatic send_frame(input logic [7:0] b, input logic stop_ok,
                             input int ready_at, input int n_cyc);
      logic [9:0] bits;
      bits = {stop_ok, b, 1'b0};
      frame_cyc = cyc;
      for (int k = 0; k < n_cyc; k++) begin
         RXD = bits[k / 10];
         if (ready_at >= 0 && k == ready_at) rx_ready = 1'b1;
         if (ready_at >= 0 && k == ready_at + 1) rx_ready = 1'b0;
         if (k == 97 && n_cyc == 100) begin
            if (stop_ok) model_frame(b, rx_ready);
            else ferr_exp++;
         end
         tick();
      end
   endtask

   int          vb;
   int          fb;
   int unsigned lat;
   logic [7:0]  rb;

   initial begin
      RESET = 1'b1;
      RXD = 1'b1;
      rx_ready = 1'b0;
      overrun_clr = 1'b0;
      repeat (3) tick();
      RESET = 1'b0;
      tick();
      check("rst_valid", 32'(rx_valid), 32'(0));
      check("rst_data", 32'(rx_data), 32'(0));
      check("rst_ferr", 32'(frame_err), 32'(0));
      check("rst_ovr", 32'(overrun), 32'(0));

      // Basic receive with the consumer always ready.
      rx_ready = 1'b1;
      idle(5);
      vb = valid_cycles;
      send_frame(8'h55, 1'b1, -1, 100);
      idle(10);
      model_pop_all();
      lat = rise_cyc - frame_cyc;
      check("basic_latency_94_98", 32'(lat >= 94 && lat <= 98), 32'(1));
      check("basic_valid_len", 32'(valid_cycles - vb), 32'(1));
      compare_delivered("basic");

      // Glitch rejection, then a normal frame.
      vb = valid_cycles;
      fb = ferr_cnt;
      RXD = 1'b0;
      repeat (3) tick();
      idle(20);
      check("glitch_no_valid", 32'(valid_cycles - vb), 32'(0));
      check("glitch_no_ferr", 32'(ferr_cnt - fb), 32'(0));
      send_frame(8'hA3, 1'b1, -1, 100);
      idle(10);
      model_pop_all();
      compare_delivered("after_glitch");

      // Framing error followed by a long break: one pulse only.
      vb = valid_cycles;
      fb = ferr_cnt;
      send_frame(8'h0F, 1'b0, -1, 100);
      RXD = 1'b0;
      repeat (200) tick();
      idle(20);
      check("break_one_ferr", 32'(ferr_cnt - fb), 32'(1));
      check("break_no_valid", 32'(valid_cycles - vb), 32'(0));
      send_frame(8'h3C, 1'b1, -1, 100);
      idle(10);
      model_pop_all();
      compare_delivered("after_break");

      // Randomized frames, some with a bad stop bit.
      for (int n = 0; n < 10; n++) begin
         rb = 8'($urandom_range(0, 255));
         send_frame(rb, ($urandom_range(0, 4) != 0), -1, 100);
         idle($urandom_range(5, 20));
      end
      model_pop_all();
      compare_delivered("random");

      // Overrun with the consumer stalled.
      rx_ready = 1'b0;
      idle(5);
      send_frame(8'h11, 1'b1, -1, 100);
      idle(5);
      send_frame(8'h22, 1'b1, -1, 100);
      idle(5);
      check("ovr_valid", 32'(rx_valid), 32'(1));
      check("ovr_data", 32'(rx_data), 32'(8'h11));
      check("ovr_flag", 32'(overrun), 32'(ovr_exp));
      overrun_clr = 1'b1;
      tick();
      overrun_clr = 1'b0;
      ovr_exp = 1'b0;
      check("ovr_cleared", 32'(overrun), 32'(0));
      rx_ready = 1'b1;
      tick();
      rx_ready = 1'b0;
      model_pop_one();
      check("ovr_after_pop_valid", 32'(rx_valid), 32'(held_q.size() != 0));
      rx_ready = 1'b1;
      repeat (5) tick();
      rx_ready = 1'b0;
      model_pop_all();
      compare_delivered("overrun");
      check("ovr_drained", 32'(rx_valid), 32'(0));

      // Push and pop in the same cycle.
      idle(5);
      send_frame(8'h11, 1'b1, -1, 100);
      idle(5);
      send_frame(8'h22, 1'b1, 97, 100);
      check("pp_data", 32'(rx_data), 32'(8'h22));
      check("pp_valid", 32'(rx_valid), 32'(1));
      check("pp_ovr", 32'(overrun), 32'(0));
      idle(5);
      rx_ready = 1'b1;
      repeat (5) tick();
      rx_ready = 1'b0;
      model_pop_all();
      compare_delivered("pushpop");

      // Reset in the middle of data bit 4 with a byte held and overrun set.
      send_frame(8'h11, 1'b1, -1, 100);
      idle(5);
      send_frame(8'h22, 1'b1, -1, 100);
      idle(5);
      send_frame(8'h10, 1'b1, -1, 55);
      RESET = 1'b1;
      tick();
      RESET = 1'b0;
      held_q.delete();
      ovr_exp = 1'b0;
      check("midrst_valid", 32'(rx_valid), 32'(0));
      check("midrst_data", 32'(rx_data), 32'(0));
      check("midrst_ferr", 32'(frame_err), 32'(0));
      check("midrst_ovr", 32'(overrun), 32'(0));
      rx_ready = 1'b1;
      idle(20);
      send_frame(8'h7E, 1'b1, -1, 100);
      idle(10);
      model_pop_all();
      compare_delivered("after_reset");

      // Five frames into a stalled consumer.
      rx_ready = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         send_frame(8'(i), 1'b1, -1, 100);
         idle(5);
      end
      check("five_ovr", 32'(overrun), 32'(ovr_exp));
      check("five_head", 32'(rx_data), 32'(8'h01));
      check("five_valid", 32'(rx_valid), 32'(1));
      rx_ready = 1'b1;
      repeat (6) tick();
      rx_ready = 1'b0;
      model_pop_all();
      compare_delivered("five");
      check("five_drained", 32'(rx_valid), 32'(0));
      overrun_clr = 1'b1;
      tick();
      overrun_clr = 1'b0;
      check("five_ovr_clr", 32'(overrun), 32'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
